dma_wr_req_split_channel: RTL and testbench
===========================================

Name: dma_wr_req_split_channel

Overview:
- Width down-converter for the DMA write-request path: 512-bit upstream beats become 256-bit downstream beats. It is the reverse of the 256-to-512 read-response packer.
- Sits between the 512-bit engine side and the 256-bit DMA/PCIe interface.
- Byte length is carried in head[31:0] and decides how many 256-bit beats are emitted, so odd-length tails produce no empty upper beat.
- Registered datapath: one 512-bit holding buffer, full throughput (2 output beats per input beat).

Parameters:
- HEAD_WIDTH, 128, width of the head sideband; head[31:0] is the byte length.
- BEAT_BYTES, 32, bytes per output beat; fixed at 256/8, not to be overridden.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- dma_wr_req_in_valid  in  1  upstream beat valid
- dma_wr_req_in_head  in  128  head; sampled only on the first beat of a packet
- dma_wr_req_in_data  in  512  data; bytes 0..31 in [255:0]
- dma_wr_req_in_last  in  1  upstream end of packet
- dma_wr_req_in_ready  out  1  upstream ready
- dma_wr_req_out_valid  out  1  downstream beat valid
- dma_wr_req_out_head  out  128  head of the current packet, held constant for the whole packet
- dma_wr_req_out_data  out  256  downstream data
- dma_wr_req_out_last  out  1  downstream end of packet
- dma_wr_req_out_ready  in  1  downstream ready
- len_mismatch_err  out  1  one-cycle pulse on an in_last/length disagreement

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; length_left=0; in_pkt=0; buffers cleared.
  - All outputs 0, including in_ready and err.
  - Reset mid-packet drops the packet with no flush.
- Handshake: AXI-stream style; a transfer occurs when valid&ready. out_valid never depends combinationally on out_ready.
- States: IDLE (buffer empty), LOW (send buf[255:0]), HIGH (send buf[511:256]).
- final_half means the current output beat drains the buffer:
  - (LOW && length_left<=32), or HIGH.
- in_ready = IDLE || (out_valid && out_ready && final_half).
  - This is combinational from out_ready and allows back-to-back packets with no bubble.
- On an input transfer:
  - The buffer loads data and in_last.
  - Next state is LOW.
  - If !in_pkt, or the current output beat is the packet's last: head_buf<=in_head; length_left<=in_head[31:0]; in_pkt<=1.
  - Otherwise head_buf and length_left are kept, because this is a continuation beat.
- Output content:
  - out_valid=1 in LOW and HIGH.
  - out_data = buf[255:0] in LOW, buf[511:256] in HIGH.
  - out_head = head_buf.
  - out_last = (length_left<=32).
- Transitions on an output transfer:
  - LOW & length_left>32: length_left-=32; go to HIGH.
  - LOW & length_left<=32: length_left<=0; in_pkt<=0; go to IDLE, or to LOW if an input is accepted in the same cycle.
  - HIGH & length_left>32: length_left-=32; go to IDLE/LOW (same rule); in_pkt stays 1.
  - HIGH & length_left<=32: packet ends, as in the LOW end case.
- No output transfer: state, buffer and counters hold. Output signals stay stable while valid&&!ready.
- Length rules:
  - Beats emitted = ceil(len/32).
  - len=0 is treated as one beat: out_last on the first LOW beat.
  - Subtraction never underflows, because the end case loads 0.
- Length is authoritative over in_last. len_mismatch_err pulses for 1 cycle, the cycle after the output transfer, when either:
  - out_last is sent from a buffer whose stored in_last=0, or
  - the final_half of a buffer with stored in_last=1 is sent with out_last=0.
  - Data flow is unaffected in both cases.
- Simultaneous output drain and input accept: the new beat is loaded, and the new head is loaded if the drained beat was the packet end.

Test Plan:
- len=64, one input beat D=(H:0xBB..,L:0xAA..), out_ready=1 → 2 output beats 0xAA..(last=0) then 0xBB..(last=1); in_ready low between the two beats; err=0.
- len=40, one input beat → out beat1 low half last=0, beat2 high half last=1; len=20 → single low-half beat last=1 and no upper beat; len=0 → single beat last=1.
- len=160, 3 input beats, in_valid held high, out_ready=1 → 5 output beats, last only on the 5th; out_head equals the first-beat head throughout; 3rd input's upper half discarded.
- Back-to-back packets len=64 and len=32, out_ready=1 → 3 consecutive output beats with no idle cycle; second packet's head appears on beat 3.
- out_ready toggled 1010… during len=128 → each data/head/last value held stable until accepted; 4 beats in order; in_ready only asserted on final_half transfers.
- len=96 with in_last=1 on beat 1 → err pulses once, after the HIGH beat; the next input beat is treated as a continuation (1 beat, last=1), and a second err pulse follows because that beat had in_last=0.
- Reset asserted while in HIGH → next cycle out_valid=0, in_ready=1 (IDLE); the following packet is processed normally.

Source files
------------

// File: rtl/dma_wr_req_split_channel.sv
// dma_wr_req_split_channel: splits 512-bit write-request beats into 256-bit beats,
// trimming the packet tail by the byte length carried in head[31:0].
module dma_wr_req_split_channel #(
    parameter int HEAD_WIDTH = 128,
    parameter int BEAT_BYTES = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dma_wr_req_in_valid,
    input  logic [HEAD_WIDTH-1:0] dma_wr_req_in_head,
    input  logic [511:0]          dma_wr_req_in_data,
    input  logic                  dma_wr_req_in_last,
    output logic                  dma_wr_req_in_ready,
    output logic                  dma_wr_req_out_valid,
    output logic [HEAD_WIDTH-1:0] dma_wr_req_out_head,
    output logic [255:0]          dma_wr_req_out_data,
    output logic                  dma_wr_req_out_last,
    input  logic                  dma_wr_req_out_ready,
    output logic                  len_mismatch_err
);
    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;
    state_t state;
    logic [511:0] data_buf;
    logic [HEAD_WIDTH-1:0] head_buf;
    logic [31:0] length_left;
    logic last_buf, in_pkt, tail, final_half, out_fire, in_fire;

    assign tail = length_left <= 32'(BEAT_BYTES);
    assign final_half = (state == LOW && tail) || state == HIGH;
    assign dma_wr_req_out_valid = state != IDLE;
    assign dma_wr_req_out_data = state == HIGH ? data_buf[511:256] : data_buf[255:0];
    assign dma_wr_req_out_head = head_buf;
    assign dma_wr_req_out_last = dma_wr_req_out_valid && tail;
    assign out_fire = dma_wr_req_out_valid && dma_wr_req_out_ready;
    // Refill in the same cycle the buffer drains so packets stream without bubbles
    assign dma_wr_req_in_ready = rst_n && (state == IDLE || (out_fire && final_half));
    assign in_fire = dma_wr_req_in_valid && dma_wr_req_in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            data_buf <= '0;
            head_buf <= '0;
            length_left <= '0;
            last_buf <= 1'b0;
            in_pkt <= 1'b0;
            len_mismatch_err <= 1'b0;
        end else begin
            len_mismatch_err <= out_fire && (tail ? !last_buf : final_half && last_buf);
            if (out_fire) begin
                state <= (state == LOW && !tail) ? HIGH : IDLE;
                length_left <= tail ? '0 : length_left - 32'(BEAT_BYTES);
                if (tail)
                    in_pkt <= 1'b0;
            end
            if (in_fire) begin
                state <= LOW;
                data_buf <= dma_wr_req_in_data;
                last_buf <= dma_wr_req_in_last;
                // A new packet starts unless this beat continues the one being drained
                if (!in_pkt || (out_fire && tail)) begin
                    head_buf <= dma_wr_req_in_head;
                    length_left <= dma_wr_req_in_head[31:0];
                    in_pkt <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_dma_wr_req_split_channel.sv
// tb_dma_wr_req_split_channel: table-driven and randomized checks of the 512-to-256 splitter
// against a packet-level model (beat lists derived from byte lengths).
module tb_dma_wr_req_split_channel;
    logic clk = 1'b0;
    logic rst_n;
    logic in_valid, in_ready, in_last, out_valid, out_last, out_ready, err;
    logic [127:0] in_head, out_head;
    logic [511:0] in_data;
    logic [255:0] out_data;

    dma_wr_req_split_channel #(.HEAD_WIDTH(128), .BEAT_BYTES(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .dma_wr_req_in_valid(in_valid),
        .dma_wr_req_in_head(in_head),
        .dma_wr_req_in_data(in_data),
        .dma_wr_req_in_last(in_last),
        .dma_wr_req_in_ready(in_ready),
        .dma_wr_req_out_valid(out_valid),
        .dma_wr_req_out_head(out_head),
        .dma_wr_req_out_data(out_data),
        .dma_wr_req_out_last(out_last),
        .dma_wr_req_out_ready(out_ready),
        .len_mismatch_err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] data;
        logic [127:0] head;
        logic         last;
        logic         err;
    } exp_t;

    typedef struct {
        logic [31:0] len;
        logic [7:0]  mask;
        int          mode;
        int          exp_out;
        int          exp_err;
    } vec_t;

    logic [511:0] in_d[$];
    logic [127:0] in_h[$];
    logic         in_l[$];
    int           in_nb[$];
    exp_t         exp_q[$];
    int checks = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++)
            r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic int in_beats(input logic [31:0] len);
        int n;
        n = (len == 0) ? 1 : int'((len + 32'd31) / 32'd32);
        return (n + 1) / 2;
    endfunction

    // Model: a packet of len bytes is ceil(len/32) (min 1) 256-bit beats taken low half first
    task automatic add_pkt(input logic [31:0] len, input logic [7:0] mask, input logic use_d, input logic [511:0] d0);
        int n, nin, nb;
        logic [127:0] h0, hj;
        logic [511:0] dj;
        exp_t e;
        n = (len == 0) ? 1 : int'((len + 32'd31) / 32'd32);
        nin = (n + 1) / 2;
        h0 = {$urandom, $urandom, $urandom, len};
        for (int j = 0; j < nin; j++) begin
            hj = (j == 0) ? h0 : {$urandom, $urandom, $urandom, $urandom};
            dj = (use_d && j == 0) ? d0 : rnd512();
            nb = (n - 2 * j >= 2) ? 2 : 1;
            in_d.push_back(dj);
            in_h.push_back(hj);
            in_l.push_back(mask[j]);
            in_nb.push_back(nb);
            for (int h = 0; h < nb; h++) begin
                e.data = (h == 1) ? dj[511:256] : dj[255:0];
                e.head = h0;
                e.last = (2 * j + h == n - 1);
                e.err = (h == nb - 1) && (mask[j] != (j == nin - 1));
                exp_q.push_back(e);
            end
        end
    endtask

    // mode 0: always ready/valid, 1: random, 2: out_ready toggles 1010...
    task automatic run(input int mode, output int nout, output int nerr);
        int ip, op, bufrem, after, cyc;
        logic pend, exp_ir, ofire, ifire;
        ip = 0; op = 0; bufrem = 0; after = 0; cyc = 0; pend = 1'b0;
        nout = 0; nerr = 0;
        @(posedge clk); #1;
        in_valid = in_d.size() > 0;
        in_data = in_d[0]; in_head = in_h[0]; in_last = in_l[0];
        out_ready = (mode == 1) ? ($urandom_range(2) != 0) : 1'b1;
        while (1) begin
            @(negedge clk);
            exp_ir = (bufrem == 0) || (out_ready && bufrem == 1);
            chk("out_valid", 256'(out_valid), 256'(bufrem > 0));
            chk("in_ready", 256'(in_ready), 256'(exp_ir));
            chk("err", 256'(err), 256'(pend));
            if (err) nerr++;
            if (bufrem > 0) begin
                chk("out_data", out_data, exp_q[op].data);
                chk("out_head", 256'(out_head), 256'(exp_q[op].head));
                chk("out_last", 256'(out_last), 256'(exp_q[op].last));
            end
            ofire = bufrem > 0 && out_ready;
            ifire = in_valid && exp_ir;
            pend = 1'b0;
            if (ofire) begin
                pend = exp_q[op].err;
                op++; bufrem--; nout++;
            end
            if (ifire) begin
                bufrem = in_nb[ip];
                ip++;
            end
            if (op == exp_q.size() && ip == in_d.size()) after++;
            if (after >= 2) break;
            if (++cyc > 2000) begin
                fails++;
                $display("FAIL timeout: got %0d of %0d beats expected", op, exp_q.size());
                break;
            end
            @(posedge clk); #1;
            if (ifire || !in_valid) begin
                in_valid = ip < in_d.size() && (mode != 1 || $urandom_range(3) != 0);
                if (ip < in_d.size()) begin
                    in_data = in_d[ip]; in_head = in_h[ip]; in_last = in_l[ip];
                end
            end
            out_ready = (mode == 0) ? 1'b1 : (mode == 2) ? !out_ready : ($urandom_range(2) != 0);
        end
        in_valid = 1'b0;
        in_d.delete(); in_h.delete(); in_l.delete(); in_nb.delete(); exp_q.delete();
    endtask

    initial begin
        vec_t vt[10];
        int nout, nerr, np, nin;
        logic [31:0] len;
        logic [7:0] m;
        logic [511:0] aabb;
        vt[0] = '{32'd64,  8'h01, 0, 2, 0};
        vt[1] = '{32'd40,  8'h01, 0, 2, 0};
        vt[2] = '{32'd20,  8'h01, 0, 1, 0};
        vt[3] = '{32'd0,   8'h01, 0, 1, 0};
        vt[4] = '{32'd160, 8'h04, 0, 5, 0};
        vt[5] = '{32'd128, 8'h02, 2, 4, 0};
        vt[6] = '{32'd96,  8'h01, 0, 3, 2};
        vt[7] = '{32'd33,  8'h01, 1, 2, 0};
        vt[8] = '{32'd64,  8'h00, 1, 2, 1};
        vt[9] = '{32'd300, 8'h10, 1, 10, 0};
        aabb = {{32{8'hBB}}, {32{8'hAA}}};
        rst_n = 1'b0; in_valid = 1'b0; in_head = '0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_in_ready", 256'(in_ready), 256'(0));
        chk("rst_out_last", 256'(out_last), 256'(0));
        chk("rst_err", 256'(err), 256'(0));
        chk("rst_out_data", out_data, 256'(0));
        chk("rst_out_head", 256'(out_head), 256'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            add_pkt(vt[i].len, vt[i].mask, i == 0, aabb);
            run(vt[i].mode, nout, nerr);
            chk($sformatf("vec%0d_beats", i), 256'(nout), 256'(vt[i].exp_out));
            chk($sformatf("vec%0d_errs", i), 256'(nerr), 256'(vt[i].exp_err));
        end
        add_pkt(32'd64, 8'h01, 1'b0, '0);
        add_pkt(32'd32, 8'h01, 1'b0, '0);
        run(0, nout, nerr);
        chk("b2b_beats", 256'(nout), 256'(3));
        // Reset while the upper half is pending
        @(posedge clk); #1;
        in_valid = 1'b1; in_head = {96'h0, 32'd64}; in_data = rnd512(); in_last = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_high_valid", 256'(out_valid), 256'(1));
        chk("pre_rst_high_data", out_data, in_data[511:256]);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", 256'(out_valid), 256'(0));
        chk("post_rst_in_ready", 256'(in_ready), 256'(1));
        add_pkt(32'd64, 8'h01, 1'b0, '0);
        run(0, nout, nerr);
        chk("post_rst_beats", 256'(nout), 256'(2));
        for (int t = 0; t < 30; t++) begin
            np = $urandom_range(3, 1);
            for (int p = 0; p < np; p++) begin
                len = 32'($urandom_range(300));
                nin = in_beats(len);
                m = ($urandom_range(4) == 0) ? 8'($urandom) : 8'(8'h01 << (nin - 1));
                add_pkt(len, m, 1'b0, '0);
            end
            run($urandom_range(2), nout, nerr);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
